clk_divider_prog: RTL
=====================

// Module: clk_divider_prog
// PURPOSE
//  Multi-channel, run-time programmable clock divider; parametrised successor to the fixed clk_divider.
//  Derives NUM_CH slow enables/clocks from the board clock (50 MHz, 20 ns period) for lab peripherals.
//  Per-channel divisor and output mode (50% toggle or 1-cycle pulse) load via valid/ready handshake;
//  updates apply glitch-free at the channel's next terminal count.
// PARAMETERS
//  NUM_CH   2   number of independent divider channels (>=1)
//  CNT_W    16  divisor/counter width in bits
//  DEF_DIV  5   reset divisor loaded into every channel (1..2^CNT_W-1)
// PORTS
//  clk        in   1                  system clock, all logic on rising edge
//  rst        in   1                  asynchronous, active-low reset (0 = reset)
//  en         in   NUM_CH             per-channel run enable
//  cfg_valid  in   1                  config request valid
//  cfg_ch     in   max(1,clog2(NUM_CH)) target channel index
//  cfg_div    in   CNT_W              new divisor D (0 is illegal)
//  cfg_mode   in   1                  0 = TOGGLE (50% duty), 1 = PULSE (1-cycle high)
//  cfg_ready  out  1                  config can be accepted for cfg_ch this cycle
//  cfg_err    out  1                  1-cycle strobe: request with cfg_div==0 rejected
//  clk_div    out  NUM_CH             divided outputs (registered)
//  tick       out  NUM_CH             1-cycle strobe on every 0->1 edge of clk_div[i]
// BEHAVIOUR
//  Reset (rst=0, async): cnt=0, div=DEF_DIV, mode=TOGGLE, pending=0, clk_div=0, tick=0, cfg_err=0.
//  Counter per channel: en[i]=0 -> cnt held 0, clk_div[i]<=0, tick[i]<=0 on next edge.
//   en[i]=1 -> cnt increments each edge; terminal when cnt==D-1: cnt<=0 and terminal action.
//   TOGGLE: clk_div toggles at terminal -> period 2*D clk, 50% duty.
//   PULSE: clk_div<=1 at terminal edge, 0 at every other edge; D=1 -> clk_div constantly 1.
//   First clk_div rise occurs at the D-th rising edge with en sampled high (cnt starts from 0).
//  Handshake: accept when cfg_valid & cfg_ready; cfg_ready = ~pending[cfg_ch] (combinational).
//   Accepted with cfg_div!=0 -> stored in channel shadow regs, pending[cfg_ch]<=1.
//   Accepted with cfg_div==0 -> nothing stored, cfg_err=1 for one cycle, cfg_ready stays 1.
//  Apply: pending shadow copies into active div/mode at that channel's terminal edge (same edge
//   performs the new mode's terminal action, cnt<=0); if en[i]=0, applies on the next edge.
//   pending clears on apply; cfg_ready for that channel returns high the following cycle.
//  Mode change at apply: TOGGLE->PULSE clk_div<=1 for one cycle; PULSE->TOGGLE clk_div toggles from 0.
//  Simultaneous accept and apply on same channel: impossible (ready low while pending).
//  Channels fully independent; config to channel i never disturbs channel j.
//  en deasserted mid-period: count lost; pending config still applies on next edge.
//  cfg_ch >= NUM_CH: cfg_ready=0, request ignored.
//  Reset mid-operation: immediate return to reset values; shadow/pending discarded.
//  tick[i] = registered, high exactly in the cycle clk_div[i] first reads 1.
// TESTING
//  1 rst=0 100 ns, release, en=2'b01 -> ch0 TOGGLE D=5: clk_div[0] period 200 ns, 100 ns high; ch1 stays 0.
//  2 cfg ch0 D=3 PULSE mid-period -> cfg_ready low until terminal; then clk_div[0] high 20 ns every 60 ns.
//  3 cfg_div=0 -> cfg_err one cycle, no pending, output period unchanged.
//  4 ch1 PULSE D=1, en[1]=1 -> clk_div[1] constantly 1, tick[1] once; ch0 unaffected.
//  5 rst=0 mid-count for 60 ns -> outputs 0 asynchronously, div back to 5, pending cleared.
//  6 en[0] dropped after 3 clk of count, re-raised -> next rise exactly 5 clk later.

Source files
------------

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: multi-channel run-time programmable clock divider.
// Ports: clk, rst (async, active-low); en[NUM_CH] per-channel run enable;
//   cfg_valid/cfg_ch/cfg_div/cfg_mode config request, cfg_ready handshake,
//   cfg_err reject strobe; clk_div[NUM_CH] divided outputs, tick[NUM_CH] rise strobes.
module clk_divider_prog #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 5,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    localparam logic M_TOGGLE = 1'b0;
    localparam logic M_PULSE  = 1'b1;

    logic [NUM_CH-1:0] w_pend;
    logic              w_ready;
    logic              w_acc;
    logic              w_div_nz;
    logic              r_err;

    // Out-of-range channel indices never match, so ready stays low for them.
    always_comb begin
        w_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(cfg_ch) == i) w_ready = ~w_pend[i];
        end
    end

    assign w_acc     = cfg_valid & w_ready;
    assign w_div_nz  = |cfg_div;
    assign cfg_ready = w_ready;
    assign cfg_err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= w_acc & ~w_div_nz;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_sh_div;
        logic             r_mode;
        logic             r_sh_mode;
        logic             r_pend;
        logic             r_q;
        logic             r_tick;
        logic             w_term;
        logic             w_load;
        logic             w_apply;
        logic             w_nmode;
        logic             w_nq;

        assign w_term  = (r_cnt == r_div - CNT_W'(1));
        assign w_load  = w_acc & w_div_nz & (32'(cfg_ch) == g);
        assign w_apply = r_pend & (~en[g] | w_term);
        // The terminal edge that applies a config acts in the new mode.
        assign w_nmode = r_pend ? r_sh_mode : r_mode;

        always_comb begin
            w_nq = r_q;
            if (!en[g]) begin
                w_nq = 1'b0;
            end else if (w_term) begin
                if (w_nmode == M_PULSE)
                    w_nq = 1'b1;
                else if (r_pend && r_mode == M_PULSE)
                    w_nq = 1'b1;  // PULSE->TOGGLE restarts from low
                else
                    w_nq = ~r_q;
            end else if (r_mode == M_PULSE) begin
                w_nq = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_cnt     <= '0;
                r_div     <= CNT_W'(DEF_DIV);
                r_mode    <= M_TOGGLE;
                r_sh_div  <= CNT_W'(DEF_DIV);
                r_sh_mode <= M_TOGGLE;
                r_pend    <= 1'b0;
                r_q       <= 1'b0;
                r_tick    <= 1'b0;
            end else begin
                r_q    <= w_nq;
                r_tick <= w_nq & ~r_q;
                if (!en[g] || w_term) r_cnt <= '0;
                else                  r_cnt <= r_cnt + CNT_W'(1);
                if (w_apply) begin
                    r_div  <= r_sh_div;
                    r_mode <= r_sh_mode;
                    r_pend <= 1'b0;
                end else if (w_load) begin
                    r_sh_div  <= cfg_div;
                    r_sh_mode <= cfg_mode;
                    r_pend    <= 1'b1;
                end
            end
        end

        assign clk_div[g] = r_q;
        assign tick[g]    = r_tick;
        assign w_pend[g]  = r_pend;
    end

endmodule
